// File: rtl/lcd_hd44780_monitor.sv
// lcd_hd44780_monitor: receive-side HD44780 write-bus decoder with a shadow of the visible DDRAM,
// flag state, busy timing model and sticky protocol-violation flags.
module lcd_hd44780_monitor #(
  parameter int BUSY_CYC     = 2000,
  parameter int BUSY_CLR_CYC = 82000
) (
  input  logic         iCLK,
  input  logic         iRST_N,
  input  logic [7:0]   LCD_DATA,
  input  logic         LCD_RW,
  input  logic         LCD_EN,
  input  logic         LCD_RS,
  output logic [127:0] oLINE1,
  output logic [127:0] oLINE2,
  output logic [6:0]   oADDR,
  output logic [7:0]   oFLAGS,
  output logic         oBUSY,
  output logic         oCMD_VALID,
  output logic         oCHAR_VALID,
  output logic [7:0]   oCODE,
  output logic [2:0]   oERR
);
  localparam int MAXC = BUSY_CLR_CYC > BUSY_CYC ? BUSY_CLR_CYC : BUSY_CYC;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [10:0] s1, s2;
  logic en_q, strobe, wr, accept, rs, rw, long_cmd;
  logic [7:0] d;
  logic [6:0] ac_next;
  assign oBUSY = state == BUSY;
  always_comb begin
    rs       = s2[9];
    rw       = s2[8];
    d        = s2[7:0];
    strobe   = en_q & ~s2[10];
    wr       = strobe & ~rw;
    accept   = wr & (state == IDLE);
    long_cmd = ~rs & (d[7:2] == 6'd0) & (d[1:0] != 2'd0);
    ac_next  = oFLAGS[2] ? (oADDR == 7'h27 ? 7'h40 : oADDR == 7'h67 ? 7'h00 : oADDR + 7'd1)
                         : (oADDR == 7'h00 ? 7'h67 : oADDR == 7'h40 ? 7'h27 : oADDR - 7'd1);
  end
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      s1          <= '0;
      s2          <= '0;
      en_q        <= 1'b0;
      state       <= IDLE;
      cnt         <= '0;
      oLINE1      <= {16{8'h20}};
      oLINE2      <= {16{8'h20}};
      oADDR       <= 7'h00;
      oFLAGS      <= 8'b1000_0100;
      oCMD_VALID  <= 1'b0;
      oCHAR_VALID <= 1'b0;
      oCODE       <= 8'h00;
      oERR        <= 3'b000;
    end else begin
      s1          <= {LCD_EN, LCD_RS, LCD_RW, LCD_DATA};
      s2          <= s1;
      en_q        <= s2[10];
      oCMD_VALID  <= 1'b0;
      oCHAR_VALID <= 1'b0;
      if (strobe && rw) oERR[2] <= 1'b1;
      if (wr && state == BUSY) oERR[0] <= 1'b1;
      if (state == BUSY) begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) state <= IDLE;
      end
      if (accept) begin
        state <= BUSY;
        cnt   <= long_cmd ? CW'(BUSY_CLR_CYC) : CW'(BUSY_CYC);
        oCODE <= d;
        if (rs) begin
          oCHAR_VALID <= 1'b1;
          // CGRAM contents are not modelled, so a CGRAM-mode data byte is just dropped
          if (!oFLAGS[0]) begin
            if (oADDR[6:4] == 3'b000) oLINE1[{oADDR[3:0], 3'b000} +: 8] <= d;
            if (oADDR[6:4] == 3'b100) oLINE2[{oADDR[3:0], 3'b000} +: 8] <= d;
            oADDR <= ac_next;
          end
        end else begin
          oCMD_VALID <= 1'b1;
          if (d[7]) begin
            oADDR     <= d[6:0];
            oFLAGS[0] <= 1'b0;
            if (d[5:0] >= 6'h28) oERR[1] <= 1'b1;
          end else if (d[6]) begin
            oFLAGS[0] <= 1'b1;
          end else if (d[5]) begin
            oFLAGS[7:6] <= d[4:3];
          end else if (d[4]) begin
            oFLAGS <= oFLAGS;
          end else if (d[3]) begin
            oFLAGS[5:3] <= d[2:0];
          end else if (d[2]) begin
            oFLAGS[2:1] <= d[1:0];
          end else if (d[1]) begin
            oADDR     <= 7'h00;
            oFLAGS[0] <= 1'b0;
          end else if (d[0]) begin
            oLINE1    <= {16{8'h20}};
            oLINE2    <= {16{8'h20}};
            oADDR     <= 7'h00;
            oFLAGS[2] <= 1'b1;
            oFLAGS[0] <= 1'b0;
          end
        end
      end
    end
  end
endmodule
